// File: rtl/candy_id_pkg.sv
// candy_id_pipe shared types: field widths, type codes, decoded bundle.
// Imported by the decoder and the skid-buffered decode stage.
package candy_id_pkg;

  localparam int OP_W   = 6;
  localparam int RA_W   = 4;
  localparam int INST_W = 24;

  typedef enum logic [1:0] {
    T_R = 2'b00,
    T_I = 2'b01,
    T_S = 2'b10,
    T_U = 2'b11
  } itype_e;

  typedef struct packed {
    logic rs1;
    logic rs2;
    logic rd;
  } en_t;

  // imm and pc are parameter-width, so they ride beside this struct
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    en_t             en;
    logic            illegal;
  } dec_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } skid_e;

endpackage

// File: rtl/candy_id_dec.sv
// candy_id_dec: combinational field extractor and immediate extender.
// Unused address fields and the R-type immediate are forced to zero.
module candy_id_dec
  import candy_id_pkg::*;
#(
  parameter int IMM_W = 32,
  parameter bit SEXT  = 1'b1
) (
  input  logic [INST_W-1:0] inst,
  output dec_t              dec,
  output logic [IMM_W-1:0]  imm
);

  itype_e ty;
  logic   sx10;
  logic   sx16;

  assign ty   = itype_e'(inst[23:22]);
  assign sx10 = SEXT & inst[9];
  assign sx16 = SEXT & inst[15];

  always_comb begin
    dec = '0;
    imm = '0;
    unique case (1'b1)
      (ty == T_R): begin
        dec.op      = inst[21:16];
        dec.rs1     = inst[15:12];
        dec.rs2     = inst[11:8];
        dec.rd      = inst[7:4];
        dec.en      = '{rs1: 1'b1, rs2: 1'b1, rd: 1'b1};
        dec.illegal = |inst[3:0];
      end
      (ty == T_I): begin
        dec.op     = {2'b00, inst[21:18]};
        dec.rs1    = inst[17:14];
        dec.rd     = inst[13:10];
        dec.en     = '{rs1: 1'b1, rs2: 1'b0, rd: 1'b1};
        imm        = {IMM_W{sx10}};
        imm[9:0]   = inst[9:0];
      end
      (ty == T_S): begin
        dec.op     = {2'b00, inst[21:18]};
        dec.rs1    = inst[17:14];
        dec.rs2    = inst[13:10];
        dec.en     = '{rs1: 1'b1, rs2: 1'b1, rd: 1'b0};
        imm        = {IMM_W{sx10}};
        imm[9:0]   = inst[9:0];
      end
      (ty == T_U): begin
        dec.op     = {4'b0000, inst[21:20]};
        dec.rd     = inst[19:16];
        dec.en     = '{rs1: 1'b0, rs2: 1'b0, rd: 1'b1};
        imm        = {IMM_W{sx16}};
        imm[15:0]  = inst[15:0];
      end
      default: begin
        dec = '0;
        imm = '0;
      end
    endcase
  end

endmodule

// File: rtl/candy_id_pipe.sv
// candy_id_pipe: handshaked decode stage with a 2-entry skid buffer.
// in_ready comes only from registered state, never from out_ready.
module candy_id_pipe
  import candy_id_pkg::*;
#(
  parameter int IMM_W = 32,
  parameter bit SEXT  = 1'b1,
  parameter int PC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst,
  input  logic [PC_W-1:0]   pc_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   op,
  output logic [RA_W-1:0]   rs1,
  output logic [RA_W-1:0]   rs2,
  output logic [RA_W-1:0]   rd,
  output logic              rs1_en,
  output logic              rs2_en,
  output logic              rd_en,
  output logic [IMM_W-1:0]  imm_out,
  output logic              illegal,
  output logic [PC_W-1:0]   pc_out
);

  dec_t             d_in;
  logic [IMM_W-1:0] imm_in;

  candy_id_dec #(
    .IMM_W (IMM_W),
    .SEXT  (SEXT)
  ) u_dec (
    .inst (inst),
    .dec  (d_in),
    .imm  (imm_in)
  );

  skid_e            st;
  skid_e            st_nx;
  logic             accept;
  logic             drain;
  logic             ld0;
  logic             ld1;
  logic             mv;

  dec_t             b0;
  dec_t             b1;
  logic [IMM_W-1:0] imm0;
  logic [IMM_W-1:0] imm1;
  logic [PC_W-1:0]  pc0;
  logic [PC_W-1:0]  pc1;

  assign in_ready  = (st != S_TWO);
  assign out_valid = (st != S_EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= S_EMPTY;
    end else begin
      st <= st_nx;
    end
  end

  always_comb begin
    st_nx = st;
    ld0   = 1'b0;
    ld1   = 1'b0;
    mv    = 1'b0;
    if (flush) begin
      st_nx = S_EMPTY;
    end else begin
      case (st)
        S_EMPTY: begin
          if (accept) begin
            st_nx = S_ONE;
            ld0   = 1'b1;
          end
        end
        S_ONE: begin
          if (accept && drain) begin
            ld0 = 1'b1;
          end else if (accept) begin
            st_nx = S_TWO;
            ld1   = 1'b1;
          end else if (drain) begin
            st_nx = S_EMPTY;
          end
        end
        S_TWO: begin
          if (drain) begin
            st_nx = S_ONE;
            mv    = 1'b1;
          end
        end
        default: st_nx = S_EMPTY;
      endcase
    end
  end

  // output register reloads from the decoder or from the skid slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b0   <= '0;
      b1   <= '0;
      imm0 <= '0;
      imm1 <= '0;
      pc0  <= '0;
      pc1  <= '0;
    end else begin
      if (ld0) begin
        b0   <= d_in;
        imm0 <= imm_in;
        pc0  <= pc_in;
      end else if (mv) begin
        b0   <= b1;
        imm0 <= imm1;
        pc0  <= pc1;
      end
      if (ld1) begin
        b1   <= d_in;
        imm1 <= imm_in;
        pc1  <= pc_in;
      end
    end
  end

  assign op      = b0.op;
  assign rs1     = b0.rs1;
  assign rs2     = b0.rs2;
  assign rd      = b0.rd;
  assign rs1_en  = b0.en.rs1;
  assign rs2_en  = b0.en.rs2;
  assign rd_en   = b0.en.rd;
  assign illegal = b0.illegal;
  assign imm_out = imm0;
  assign pc_out  = pc0;

endmodule

// File: tb/tb_candy_id_pipe.sv
// tb_candy_id_pipe: scoreboard bench, sign- and zero-extending DUTs side by side.
// Expected bundles come from a field-arithmetic model of the decode rules.
module tb_candy_id_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [23:0] inst = '0;
  logic [15:0] pc_in = '0;

  logic        in_ready, out_valid;
  logic [5:0]  op;
  logic [3:0]  rs1, rs2, rd;
  logic        rs1_en, rs2_en, rd_en, illegal;
  logic [31:0] imm_out;
  logic [15:0] pc_out;

  logic        z_in_ready, z_out_valid;
  logic [5:0]  z_op;
  logic [3:0]  z_rs1, z_rs2, z_rd;
  logic        z_rs1_en, z_rs2_en, z_rd_en, z_illegal;
  logic [31:0] z_imm;
  logic [15:0] z_pc;

  candy_id_pipe #(.IMM_W(32), .SEXT(1'b1), .PC_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1_en(rs1_en), .rs2_en(rs2_en), .rd_en(rd_en),
    .imm_out(imm_out), .illegal(illegal), .pc_out(pc_out)
  );

  candy_id_pipe #(.IMM_W(32), .SEXT(1'b0), .PC_W(16)) dutz (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(z_in_ready),
    .inst(inst), .pc_in(pc_in),
    .out_valid(z_out_valid), .out_ready(out_ready),
    .op(z_op), .rs1(z_rs1), .rs2(z_rs2), .rd(z_rd),
    .rs1_en(z_rs1_en), .rs2_en(z_rs2_en), .rd_en(z_rd_en),
    .imm_out(z_imm), .illegal(z_illegal), .pc_out(z_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [2:0]  en;
    logic [31:0] imms;
    logic [31:0] immz;
    logic        ill;
    logic [15:0] pc;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [23:0] i,
                                 input logic [15:0] pc);
    exp_t        e;
    int unsigned w, f, bits;
    e    = '0;
    w    = i;
    f    = 0;
    bits = 0;
    e.pc = pc;
    case (w >> 22)
      0: begin
        e.op  = 6'((w >> 16) & 63);
        e.rs1 = 4'((w >> 12) & 15);
        e.rs2 = 4'((w >> 8) & 15);
        e.rd  = 4'((w >> 4) & 15);
        e.en  = 3'b111;
        e.ill = (w & 15) != 0;
      end
      1: begin
        e.op  = 6'((w >> 18) & 15);
        e.rs1 = 4'((w >> 14) & 15);
        e.rd  = 4'((w >> 10) & 15);
        e.en  = 3'b101;
        f     = w & 1023;
        bits  = 10;
      end
      2: begin
        e.op  = 6'((w >> 18) & 15);
        e.rs1 = 4'((w >> 14) & 15);
        e.rs2 = 4'((w >> 10) & 15);
        e.en  = 3'b110;
        f     = w & 1023;
        bits  = 10;
      end
      default: begin
        e.op  = 6'((w >> 20) & 3);
        e.rd  = 4'((w >> 16) & 15);
        e.en  = 3'b001;
        f     = w & 65535;
        bits  = 16;
      end
    endcase
    e.immz = f;
    if (bits != 0 && f >= (32'd1 << (bits - 1)))
      e.imms = f - (32'd1 << bits);
    else
      e.imms = f;
    return e;
  endfunction

  // feeder: record every accepted instruction's expected bundle
  always @(negedge clk) begin
    if (!rst || flush)
      q.delete();
    else if (in_valid && in_ready)
      q.push_back(model(inst, pc_in));
  end

  // monitor: compare every bundle that drains
  always @(negedge clk) begin
    if (rst && !flush && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("op", 64'(op), 64'(e.op));
        chk("rs1", 64'(rs1), 64'(e.rs1));
        chk("rs2", 64'(rs2), 64'(e.rs2));
        chk("rd", 64'(rd), 64'(e.rd));
        chk("en", 64'({rs1_en, rs2_en, rd_en}), 64'(e.en));
        chk("imm_sext", 64'(imm_out), 64'(e.imms));
        chk("illegal", 64'(illegal), 64'(e.ill));
        chk("pc", 64'(pc_out), 64'(e.pc));
        chk("z_valid", 64'(z_out_valid), 64'd1);
        chk("imm_zext", 64'(z_imm), 64'(e.immz));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] i, input logic [15:0] pc);
    logic acc;
    int   n;
    n        = 0;
    inst     = i;
    pc_in    = pc;
    in_valid = 1'b1;
    forever begin
      acc = in_ready;
      step();
      if (acc) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 64'(n), 64'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_data"},
        64'({op, rs1, rs2, rd, rs1_en, rs2_en, rd_en, illegal}), 64'd0);
    chk({nm, "_imm"}, 64'(imm_out), 64'd0);
    chk({nm, "_pc"}, 64'(pc_out), 64'd0);
    chk({nm, "_oval"}, 64'(out_valid), 64'd0);
    chk({nm, "_irdy"}, 64'(in_ready), 64'd1);
  endtask

  logic [23:0] dir [6];

  initial begin
    dir[0] = 24'h0A5678;
    dir[1] = 24'h0A5670;
    dir[2] = {2'b01, 4'h5, 4'd2, 4'd3, 10'h3FF};
    dir[3] = {2'b10, 4'h9, 4'd4, 4'd6, 10'h155};
    dir[4] = 24'hE38000;
    dir[5] = 24'h000001;

    #12;
    chk_zero("reset");
    rst = 1'b1;
    step();
    chk_zero("post_reset");

    out_ready = 1'b1;
    for (int k = 0; k < 6; k++)
      send(dir[k], 16'(16'h100 + k));
    repeat (3) step();

    out_ready = 1'b0;
    send(24'h012345, 16'hA000);
    send(24'h456789, 16'hB000);
    inst     = 24'h89ABCD;
    pc_in    = 16'hC000;
    in_valid = 1'b1;
    chk("c_cycle_in_ready", 64'(in_ready), 64'd0);
    chk("c_cycle_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    send(24'h89ABCD, 16'hC000);
    repeat (4) step();

    out_ready = 1'b0;
    send(24'h111111, 16'hD000);
    send(24'h222222, 16'hE000);
    inst     = 24'h333333;
    pc_in    = 16'hF000;
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) step();

    out_ready = 1'b0;
    send(24'h4ABCDE, 16'h1234);
    chk("one_state_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("async_rst");
    step();
    rst = 1'b1;
    out_ready = 1'b1;
    send(24'hC7FFFF, 16'h4321);
    repeat (3) step();

    for (int c = 0; c < 500; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 29) == 0);
      inst      = 24'($urandom);
      pc_in     = 16'($urandom);
      step();
    end

    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (q.size() != 0 || out_valid); c++)
      step();
    chk("drain_queue", 64'(q.size()), 64'd0);
    chk("drain_valid", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
